// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: shares the single regfile write port between stage-4
// pipeline results and out-of-order memory load responses. Load responses
// are buffered in a small FIFO. The head entry is written whenever stage 4
// has an idle slot, or when a starvation hold steals a slot for it.
module cpu_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  p4_dest_reg,
  input  logic        load_issue,
  output logic        load_stall,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic [4:0]  load_dest,
  output logic        cpu_ready,
  output logic [31:0] read_data,
  output logic [4:0]  read_dest,
  output logic        p4_hold,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(STARVE_LIMIT + 1);

  localparam logic [PW-1:0] OUT_MAX = PW'(DEPTH);
  localparam logic [GW-1:0] AGE_MAX = GW'(STARVE_LIMIT - 1);

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] outstanding;
  logic [GW-1:0] age;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic issue_ok;
  logic err_set;

  // Derive FIFO status, the writeback decision and the error conditions.
  // NOTE: every signal gets a default at the top of an always_comb. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    empty      = 1'b0;
    full       = 1'b0;
    head       = '0;
    cpu_ready  = 1'b0;
    read_data  = '0;
    read_dest  = '0;
    load_stall = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    issue_ok   = 1'b0;
    err_set    = 1'b0;

    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    head  = mem[rd_ptr[AW-1:0]];

    // The head is written back on any idle stage-4 slot or on a stolen slot.
    cpu_ready = !empty && ((p4_dest_reg == 5'd0) || p4_hold);
    pop       = cpu_ready;

    // A pop in the same cycle frees the slot that a push at full lands in.
    push = load_valid && (!full || pop);

    if (!empty) begin
      read_data = head.data;
      read_dest = head.dest;
    end

    load_stall = (outstanding == OUT_MAX);
    issue_ok   = load_issue && !load_stall;

    err_set = (load_issue && load_stall)
            || (load_valid && full && !pop)
            || (pop && (outstanding == '0));
  end

  // Store incoming load responses into the circular buffer.
  // NOTE: the storage array has no reset. The pointers alone define which
  // entries are valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{data: load_data, dest: load_dest};
    end
  end

  // Advance the read and write pointers.
  // NOTE: sequential state is assigned only with <=. All flops then sample
  // pre-edge values, which avoids race-dependent simulation results.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Track loads issued but not yet written back. The count saturates at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
    end else begin
      case ({issue_ok, pop})
        2'b10:   outstanding <= outstanding + PW'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - PW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Age the waiting head entry and steal the next stage-4 slot when it starves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      age     <= '0;
      p4_hold <= 1'b0;
    end else begin
      p4_hold <= !empty && !pop && (age == AGE_MAX);
      if (empty || pop) begin
        age <= '0;
      end else if (age != AGE_MAX) begin
        age <= age + GW'(1);
      end
    end
  end

  // Latch any protocol violation until the next reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

endmodule
